// File: rtl/key_sched_ctrl_if.sv
// Handshake bundle for the AES-128 round-key scheduler:
// master-key load, run control and the round-key stream.
interface key_sched_ctrl_if;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         start;
  logic         flush;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         rk_last;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;

  modport master (
    output key_in, key_valid, start, flush, rk_ready,
    input  key_ready, rk_data, rk_idx, rk_last, rk_valid, busy
  );

  modport slave (
    input  key_in, key_valid, start, flush, rk_ready,
    output key_ready, rk_data, rk_idx, rk_last, rk_valid, busy
  );
endinterface

// File: rtl/key_sched_ctrl.sv
// AES-128 key-expansion controller: stores a master key and
// streams round keys 0..NR, one per accepted handshake.
module key_sched_ctrl #(
  parameter int unsigned NR = 10
) (
  input logic             clk,
  input logic             rst_n,
  key_sched_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READY,
    S_RUN
  } state_t;

  localparam logic [3:0] LAST = 4'(NR);

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  endfunction

  function automatic logic [127:0] ks_round(
    input logic [127:0] w,
    input logic [7:0]   rc
  );
    logic [127:0] n;
    n[7:0]    = w[7:0]   ^ sbox(w[111:104]) ^ rc;
    n[15:8]   = w[15:8]  ^ sbox(w[119:112]);
    n[23:16]  = w[23:16] ^ sbox(w[127:120]);
    n[31:24]  = w[31:24] ^ sbox(w[103:96]);
    n[63:32]  = w[63:32]  ^ n[31:0];
    n[95:64]  = w[95:64]  ^ n[63:32];
    n[127:96] = w[127:96] ^ n[95:64];
    return n;
  endfunction

  state_t       r_state;
  state_t       w_state_nx;
  logic [127:0] r_master;
  logic [127:0] r_work;
  logic [7:0]   r_rcon;
  logic [3:0]   r_idx;

  logic w_accept;
  logic w_start;
  logic w_adv;
  logic w_step;
  logic w_done;

  assign bus.key_ready = (r_state != S_RUN);
  assign bus.rk_valid  = (r_state == S_RUN);
  assign bus.busy      = (r_state == S_RUN);
  assign bus.rk_data   = r_work;
  assign bus.rk_idx    = r_idx;
  assign bus.rk_last   = (r_idx == LAST);

  assign w_accept = bus.key_valid & bus.key_ready
                  & ~bus.flush;
  assign w_start  = bus.start & (r_state == S_READY)
                  & ~bus.key_valid & ~bus.flush;
  assign w_adv    = (r_state == S_RUN) & bus.rk_ready
                  & ~bus.flush;
  assign w_step   = w_adv & (r_idx != LAST);
  assign w_done   = w_adv & (r_idx == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (bus.flush) begin
      w_state_nx = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_accept) w_state_nx = S_READY;
        S_READY: begin
          if (w_accept)     w_state_nx = S_READY;
          else if (w_start) w_state_nx = S_RUN;
        end
        S_RUN: if (w_done) w_state_nx = S_READY;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_master <= '0;
      r_work   <= '0;
      r_rcon   <= 8'h01;
      r_idx    <= '0;
    end else if (bus.flush) begin
      r_master <= '0;
      r_work   <= '0;
      r_rcon   <= '0;
      r_idx    <= '0;
    end else begin
      if (w_accept) r_master <= bus.key_in;
      if (w_start) begin
        r_work <= r_master;
        r_rcon <= 8'h01;
        r_idx  <= '0;
      end else if (w_step) begin
        r_work <= ks_round(r_work, r_rcon);
        r_rcon <= {r_rcon[6:0], 1'b0}
                ^ (r_rcon[7] ? 8'h1b : 8'h00);
        r_idx  <= r_idx + 4'd1;
      end
    end
  end

endmodule
